mc_control_fsm: RTL and testbench

- Multi-cycle control unit that drives the ALU's `alu_ctrl`/`src_a`/`src_b` interface. It also generates all datapath enables.
- Decodes the 6-bit opcode and funct fields of the latched instruction. Sequences FETCH/DECODE/execute/writeback states, one state per clock.
- Consumes the ALU `zero` flag to resolve branches.
- Sits between the instruction register and the multi-cycle datapath: ALU, register file, memory port, PC.

---
 rtl/mc_control_fsm.sv | 180 ++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// Multi-cycle control unit: sequences FETCH/DECODE/execute/writeback for a
// small MIPS-like datapath and drives the ALU controls, mux selects and all
// datapath write enables. Outputs are decoded from the current state only,
// except alu_ctrl in EXEC (funct-dependent) and pc_en in BRANCH (zero flag).
module mc_control_fsm #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               iord,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         alu_ctrl,
  output logic [1:0]         pc_src,
  output logic               pc_en,
  output logic [STATE_W-1:0] state_o
);

  // State encodings
  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_ADDIEX = 4'd9;
  localparam logic [3:0] S_ADDIWB = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [3:0] r_state;
  logic [3:0] w_next_state;
  logic [2:0] w_funct_ctrl;
  logic       w_ir_write;
  logic       w_mem_write;
  logic       w_reg_write;
  logic       w_pc_en;

  // State register; reset returns to FETCH without waiting for a clock.
  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next_state;
  end

  // Next-state decode; unknown opcodes and unused encodings fall to FETCH.
  // NOTE: a default assignment at the top of each always_comb guarantees no
  // latch is inferred for paths a case item forgets to assign.
  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_FETCH:  w_next_state = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next_state = S_MEMADR;
          OP_RTYPE:     w_next_state = S_EXEC;
          OP_BEQ:       w_next_state = S_BRANCH;
          OP_ADDI:      w_next_state = S_ADDIEX;
          OP_J:         w_next_state = S_JUMP;
          default:      w_next_state = S_FETCH;
        endcase
      end
      S_MEMADR: w_next_state = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  w_next_state = S_MEMWB;
      S_EXEC:   w_next_state = S_ALUWB;
      S_ADDIEX: w_next_state = S_ADDIWB;
      default:  w_next_state = S_FETCH;
    endcase
  end

  // R-type funct to ALU operation; unrecognised funct performs an add.
  always_comb begin
    w_funct_ctrl = ALU_ADD;
    case (funct)
      6'b100000: w_funct_ctrl = ALU_ADD;
      6'b100010: w_funct_ctrl = ALU_SUB;
      6'b100100: w_funct_ctrl = ALU_AND;
      6'b100101: w_funct_ctrl = ALU_OR;
      6'b101010: w_funct_ctrl = ALU_SLT;
      default:   w_funct_ctrl = ALU_ADD;
    endcase
  end

  // Per-state output decode; anything not set for a state stays 0.
  always_comb begin
    iord        = 1'b0;
    w_mem_write = 1'b0;
    w_ir_write  = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    w_reg_write = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_ctrl    = ALU_AND;
    pc_src      = 2'b00;
    w_pc_en     = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_ir_write = 1'b1;
        alu_src_b  = 2'b01;
        alu_ctrl   = ALU_ADD;
        w_pc_en    = 1'b1;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_ctrl  = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_ctrl  = ALU_ADD;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        w_reg_write = 1'b1;
        mem_to_reg  = 1'b1;
      end
      S_MEMWR: begin
        iord        = 1'b1;
        w_mem_write = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_ctrl  = w_funct_ctrl;
      end
      S_ALUWB: begin
        reg_dst     = 1'b1;
        w_reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_ctrl  = ALU_SUB;
        pc_src    = 2'b01;
        w_pc_en   = zero;
      end
      S_ADDIWB: w_reg_write = 1'b1;
      S_JUMP: begin
        pc_src  = 2'b10;
        w_pc_en = 1'b1;
      end
      default: ;
    endcase
  end

  // Write enables are masked directly by reset so nothing is written while
  // rst_n is low, even though the state already reads FETCH.
  assign ir_write  = w_ir_write  & rst_n;
  assign mem_write = w_mem_write & rst_n;
  assign reg_write = w_reg_write & rst_n;
  assign pc_en     = w_pc_en     & rst_n;

  assign state_o = STATE_W'(r_state);

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: walks each instruction class through
// its state sequence and checks the state-specific outputs with
// hand-computed expectations. Inputs change on the falling edge; outputs are
// sampled 1 ns later.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, pc_en;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_ctrl;
  logic [3:0] state_o;

  int vectors = 0;
  int miscompares = 0;

  mc_control_fsm #(.STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
    .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
    .pc_src(pc_src), .pc_en(pc_en), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; op = 6'b100011; funct = 6'b000000; zero = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    vectors++;
    if (state_o !== 4'd0) begin miscompares++; $display("FAIL reset_state: got %0d expected 0", state_o); end
    vectors++;
    if ({pc_en, ir_write, reg_write, mem_write} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_writes: got %b expected 0000", {pc_en, ir_write, reg_write, mem_write});
    end
    vectors++;
    if ({alu_src_b, alu_ctrl} !== 5'b01_010) begin
      miscompares++; $display("FAIL reset_fetch_alu: got %b expected 01010", {alu_src_b, alu_ctrl});
    end
    rst_n = 1'b1; #1;
    vectors++;
    if ({ir_write, pc_en} !== 2'b11) begin
      miscompares++; $display("FAIL release_fetch: got %b expected 11", {ir_write, pc_en});
    end
    @(negedge clk); #1;
    vectors++;
    if (state_o !== 4'd1) begin miscompares++; $display("FAIL release_decode: got %0d expected 1", state_o); end
    // Return to FETCH at a falling edge for the following tests.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_lw();
    logic [3:0] seq [6];
    seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    op = 6'b100011;
    for (int i = 0; i < 6; i++) begin
      #1;
      vectors++;
      if (state_o !== seq[i]) begin miscompares++; $display("FAIL lw_state[%0d]: got %0d expected %0d", i, state_o, seq[i]); end
      if (seq[i] == 4'd2) begin
        vectors++;
        if ({alu_src_a, alu_src_b, alu_ctrl} !== 6'b1_10_010) begin
          miscompares++; $display("FAIL lw_memadr: got %b expected 110010", {alu_src_a, alu_src_b, alu_ctrl});
        end
      end
      if (seq[i] == 4'd3) begin
        vectors++;
        if ({iord, mem_write, reg_write} !== 3'b100) begin
          miscompares++; $display("FAIL lw_memrd: got %b expected 100", {iord, mem_write, reg_write});
        end
      end
      if (seq[i] == 4'd4) begin
        vectors++;
        if ({reg_write, mem_to_reg, reg_dst} !== 3'b110) begin
          miscompares++; $display("FAIL lw_memwb: got %b expected 110", {reg_write, mem_to_reg, reg_dst});
        end
      end
      if (i < 5) @(negedge clk);
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fvals [3];
    logic [2:0] cvals [3];
    logic [3:0] seq [5];
    fvals = '{6'b100010, 6'b101010, 6'b111111};
    cvals = '{3'b110, 3'b111, 3'b010};
    seq = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    op = 6'b000000;
    for (int k = 0; k < 3; k++) begin
      funct = fvals[k];
      for (int i = 0; i < 5; i++) begin
        #1;
        vectors++;
        if (state_o !== seq[i]) begin miscompares++; $display("FAIL rtype%0d_state[%0d]: got %0d expected %0d", k, i, state_o, seq[i]); end
        if (seq[i] == 4'd6) begin
          vectors++;
          if ({alu_src_a, alu_src_b, alu_ctrl} !== {1'b1, 2'b00, cvals[k]}) begin
            miscompares++; $display("FAIL rtype%0d_exec: got %b expected %b", k, {alu_src_a, alu_src_b, alu_ctrl}, {1'b1, 2'b00, cvals[k]});
          end
        end
        if (seq[i] == 4'd7) begin
          vectors++;
          if ({reg_dst, reg_write, mem_to_reg} !== 3'b110) begin
            miscompares++; $display("FAIL rtype%0d_aluwb: got %b expected 110", k, {reg_dst, reg_write, mem_to_reg});
          end
        end
        if (i < 4) @(negedge clk);
      end
    end
  endtask

  task automatic test_beq();
    logic [3:0] seq [4];
    seq = '{4'd0, 4'd1, 4'd8, 4'd0};
    op = 6'b000100;
    for (int k = 0; k < 2; k++) begin
      zero = (k == 0);
      for (int i = 0; i < 4; i++) begin
        #1;
        vectors++;
        if (state_o !== seq[i]) begin miscompares++; $display("FAIL beq%0d_state[%0d]: got %0d expected %0d", k, i, state_o, seq[i]); end
        if (seq[i] == 4'd8) begin
          vectors++;
          if ({pc_en, pc_src, alu_ctrl, alu_src_a} !== {(k == 0), 2'b01, 3'b110, 1'b1}) begin
            miscompares++; $display("FAIL beq%0d_branch: got %b expected %b", k, {pc_en, pc_src, alu_ctrl, alu_src_a}, {(k == 0), 2'b01, 3'b110, 1'b1});
          end
          // pc_en follows zero combinationally inside BRANCH.
          zero = ~zero; #1;
          vectors++;
          if (pc_en !== (k != 0)) begin
            miscompares++; $display("FAIL beq%0d_zero_toggle: got %b expected %b", k, pc_en, (k != 0));
          end
          zero = ~zero;
        end
        if (i < 3) @(negedge clk);
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_sw();
    logic [3:0] seq [5];
    seq = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
    op = 6'b101011;
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++;
      if (state_o !== seq[i]) begin miscompares++; $display("FAIL sw_state[%0d]: got %0d expected %0d", i, state_o, seq[i]); end
      vectors++;
      if ({mem_write, iord} !== {2{seq[i] == 4'd5}}) begin
        miscompares++; $display("FAIL sw_mem[%0d]: got %b expected %b", i, {mem_write, iord}, {2{seq[i] == 4'd5}});
      end
      if (i < 4) @(negedge clk);
    end
  endtask

  task automatic test_addi();
    logic [3:0] seq [5];
    seq = '{4'd0, 4'd1, 4'd9, 4'd10, 4'd0};
    op = 6'b001000;
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++;
      if (state_o !== seq[i]) begin miscompares++; $display("FAIL addi_state[%0d]: got %0d expected %0d", i, state_o, seq[i]); end
      if (seq[i] == 4'd10) begin
        vectors++;
        if ({reg_write, reg_dst, mem_to_reg} !== 3'b100) begin
          miscompares++; $display("FAIL addi_wb: got %b expected 100", {reg_write, reg_dst, mem_to_reg});
        end
      end
      if (i < 4) @(negedge clk);
    end
  endtask

  task automatic test_jump_and_invalid();
    logic [3:0] seq [4];
    seq = '{4'd0, 4'd1, 4'd11, 4'd0};
    op = 6'b000010;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++;
      if (state_o !== seq[i]) begin miscompares++; $display("FAIL j_state[%0d]: got %0d expected %0d", i, state_o, seq[i]); end
      if (seq[i] == 4'd11) begin
        vectors++;
        if ({pc_src, pc_en, ir_write} !== 4'b1010) begin
          miscompares++; $display("FAIL j_jump: got %b expected 1010", {pc_src, pc_en, ir_write});
        end
      end
      if (i < 3) @(negedge clk);
    end
    op = 6'b111111;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (state_o !== seq[i == 2 ? 3 : i]) begin
        miscompares++; $display("FAIL invalid_state[%0d]: got %0d expected %0d", i, state_o, seq[i == 2 ? 3 : i]);
      end
      if (i < 2) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_aluwb();
    op = 6'b000000; funct = 6'b100000;
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if ({state_o, reg_write} !== {4'd7, 1'b1}) begin
      miscompares++; $display("FAIL mid_pre: got %0d/%b expected 7/1", state_o, reg_write);
    end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({state_o, reg_write, pc_en, ir_write} !== {4'd0, 3'b000}) begin
      miscompares++; $display("FAIL mid_abort: got %0d/%b expected 0/000", state_o, {reg_write, pc_en, ir_write});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    vectors++;
    if (state_o !== 4'd1) begin miscompares++; $display("FAIL mid_recover: got %0d expected 1", state_o); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype();
    test_beq();
    test_sw();
    test_addi();
    test_jump_and_invalid();
    test_reset_mid_aluwb();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
